// File: rtl/rs485_led_tx.sv
// RS485 LED-state frame transmitter: 8N1 UART (8E1 when
// RS485_LED_TX_PARITY_EN is defined) with driver-enable guard bit-times.
module rs485_led_tx #(
   parameter logic [25:0] CLK_FREQ = 26'd50_000_000,
   parameter logic [19:0] UART_BPS = 20'd9600
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] pi_data,
   input  logic       pi_flag,
   output logic       busy,
   output logic       tx,
   output logic       re_de
);

   localparam logic [15:0] BIT_LEN  = 16'(CLK_FREQ / 26'(UART_BPS));
   localparam logic [15:0] BIT_LAST = BIT_LEN - 16'd1;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LEAD   = 3'd1;
   localparam logic [2:0] START  = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [2:0] TAIL   = 3'd5;
`ifdef RS485_LED_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd6;
   localparam logic [2:0] AFTER_DATA = PARITY;
`else
   localparam logic [2:0] AFTER_DATA = STOP;
`endif

   logic [2:0]  state;
   logic [15:0] cnt;
   logic [2:0]  idx;
   logic [7:0]  shreg;
   logic        bit_end;

   assign bit_end = (cnt == BIT_LAST);

   // Frame sequencer: baud counter, bit index and latched byte
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= IDLE;
         cnt   <= 16'd0;
         idx   <= 3'd0;
         shreg <= 8'd0;
      end else if (state == IDLE) begin
         cnt <= 16'd0;
         idx <= 3'd0;
         if (pi_flag && !busy) begin
            shreg <= pi_data;
            state <= LEAD;
         end
      end else if (!bit_end) begin
         cnt <= cnt + 16'd1;
      end else begin
         cnt <= 16'd0;
         unique case (state)
            LEAD:  state <= START;
            START: state <= DATA;
            DATA: begin
               idx <= idx + 3'd1;
               if (idx == 3'd7) state <= AFTER_DATA;
            end
`ifdef RS485_LED_TX_PARITY_EN
            PARITY: state <= STOP;
`endif
            STOP:  state <= TAIL;
            TAIL:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Registered line outputs decoded from the sequencer state
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         tx    <= 1'b1;
         re_de <= 1'b0;
         busy  <= 1'b0;
      end else begin
         busy  <= (state != IDLE);
         re_de <= (state != IDLE);
         unique case (state)
            START:  tx <= 1'b0;
            DATA:   tx <= shreg[idx];
`ifdef RS485_LED_TX_PARITY_EN
            PARITY: tx <= ^shreg;
`endif
            default: tx <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_rs485_led_tx.sv
// Self-checking bench for rs485_led_tx: B=10 instance for frame checks,
// default-parameter instance for the long bit-period check.
module tb_rs485_led_tx;

   localparam int B  = 10;
   localparam int BD = 5208;
`ifdef RS485_LED_TX_PARITY_EN
   localparam int NB = 13;
`else
   localparam int NB = 12;
`endif

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [7:0] pi_data;
   logic       pi_flag;
   logic       busy, tx, re_de;
   logic [7:0] data2;
   logic       flag2;
   logic       busy2, tx2, re_de2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 sys_clk = ~sys_clk;

   rs485_led_tx #(
      .CLK_FREQ(26'd1_000_000),
      .UART_BPS(20'd100_000)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .pi_data(pi_data),
      .pi_flag(pi_flag),
      .busy(busy),
      .tx(tx),
      .re_de(re_de)
   );

   rs485_led_tx dut2 (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .pi_data(data2),
      .pi_flag(flag2),
      .busy(busy2),
      .tx(tx2),
      .re_de(re_de2)
   );

   // Send one byte starting at a negedge; check every cycle against the
   // line-level bit list of the frame. Optionally pulse pi_flag mid-frame.
   task automatic send_frame(input logic [7:0] d, input bit inject,
                             input string name);
      logic bits[$];
      logic par;
      logic [2:0] exp, got;
      int total;
      par = 1'b0;
      bits.push_back(1'b1);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         bits.push_back(d[i]);
         par = par ^ d[i];
      end
`ifdef RS485_LED_TX_PARITY_EN
      bits.push_back(par);
`endif
      bits.push_back(1'b1);
      bits.push_back(1'b1);
      total = bits.size() * B;
      pi_data = d;
      pi_flag = 1'b1;
      @(posedge sys_clk);
      #1;
      pi_flag = 1'b0;
      pi_data = 8'($urandom);
      for (int off = 0; off <= total + 1; off++) begin
         @(negedge sys_clk);
         if (off == 0 || off == total + 1)
            exp = 3'b001;
         else
            exp = {2'b11, bits[(off - 1) / B]};
         got = {busy, re_de, tx};
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s off=%0d {busy,re_de,tx} got %b want %b",
                     name, off, got, exp);
         end
         if (inject && (off == 29 || off == 59)) begin
            pi_flag = 1'b1;
            pi_data = ~d;
         end else begin
            pi_flag = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      sys_rst = 1'b1;
      pi_flag = 1'b0;
      pi_data = 8'h00;
      flag2   = 1'b0;
      data2   = 8'h00;
      repeat (3) @(negedge sys_clk);
      n_chk++;
      if ({busy, re_de, tx} !== 3'b001) begin
         n_fail++;
         $display("FAIL reset_hold got %b want 001", {busy, re_de, tx});
      end
      sys_rst = 1'b0;
      repeat (3) @(negedge sys_clk);
      n_chk++;
      if ({busy, re_de, tx, busy2, re_de2, tx2} !== 6'b001001) begin
         n_fail++;
         $display("FAIL reset_idle got %b want 001001",
                  {busy, re_de, tx, busy2, re_de2, tx2});
      end
   endtask

   task automatic test_basic;
      send_frame(8'h05, 1'b0, "frame_05");
      send_frame(8'hA3, 1'b0, "frame_A3");
   endtask

   task automatic test_random;
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(3, 0)) @(negedge sys_clk);
         send_frame(8'($urandom), 1'b0, "frame_rand");
      end
   endtask

   task automatic test_ignore;
      send_frame(8'($urandom), 1'b1, "frame_ignore");
   endtask

   task automatic test_back_to_back;
      send_frame(8'h3C, 1'b0, "b2b_first");
      send_frame(8'hFF, 1'b0, "b2b_second");
   endtask

   task automatic test_reset_mid;
      @(negedge sys_clk);
      pi_data = 8'hB6;
      pi_flag = 1'b1;
      @(posedge sys_clk);
      #1;
      pi_flag = 1'b0;
      repeat (55) @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      n_chk++;
      if ({busy, re_de, tx} !== 3'b001) begin
         n_fail++;
         $display("FAIL reset_mid got %b want 001", {busy, re_de, tx});
      end
      @(negedge sys_clk);
      sys_rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge sys_clk);
         n_chk++;
         if ({busy, re_de, tx} !== 3'b001) begin
            n_fail++;
            $display("FAIL post_reset_idle cyc=%0d got %b want 001",
                     i, {busy, re_de, tx});
         end
      end
      send_frame(8'($urandom), 1'b0, "post_reset_frame");
   endtask

   task automatic test_default_rate;
      int busy_cnt, low_cnt;
      bit seen_end, low_done;
      busy_cnt = 0;
      low_cnt  = 0;
      seen_end = 1'b0;
      low_done = 1'b0;
      @(negedge sys_clk);
      data2 = 8'h01;
      flag2 = 1'b1;
      @(posedge sys_clk);
      #1;
      flag2 = 1'b0;
      for (int n = 0; n < 70000 && !seen_end; n++) begin
         @(negedge sys_clk);
         if (busy2) busy_cnt++;
         if (!tx2 && !low_done) low_cnt++;
         if (tx2 && low_cnt > 0) low_done = 1'b1;
         if (busy_cnt > 0 && !busy2) seen_end = 1'b1;
      end
      n_chk++;
      if (!seen_end) begin
         n_fail++;
         $display("FAIL default_timeout busy never fell, busy=%0d cycles",
                  busy_cnt);
      end
      n_chk++;
      if (low_cnt != BD) begin
         n_fail++;
         $display("FAIL default_start_width got %0d want %0d", low_cnt, BD);
      end
      n_chk++;
      if (busy_cnt != NB * BD) begin
         n_fail++;
         $display("FAIL default_busy_len got %0d want %0d",
                  busy_cnt, NB * BD);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_ignore();
      test_back_to_back();
      test_reset_mid();
      test_default_rate();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
